// File: rtl/window_seq_pkg.sv
// -----------------------------------------------------------------------------
// window_seq_pkg
// Shared constants and types for the window address sequencer.
//   AW         : column/line address width
//   TAPS       : window width in taps
//   HALF       : distance from window base to window centre
//   seq_state_t: sequencer states (IDLE, RUN, GAP)
//   calc_center: base address to centre column, wrapping mod 2^AW
// -----------------------------------------------------------------------------
package window_seq_pkg;

   localparam int AW   = 10;
   localparam int TAPS = 11;
   localparam int HALF = (TAPS - 1) / 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } seq_state_t;

   // Centre column of the window whose leftmost tap sits at base_adr.
   // Wraps silently; the fan-out saturates out-of-range taps itself.
   function automatic logic [AW-1:0] calc_center(input logic [AW-1:0] base_adr);
      logic [AW-1:0] half_v;
      half_v      = AW'(HALF);
      calc_center = base_adr + half_v;
   endfunction

endpackage

// File: rtl/window_gap_timer.sv
// -----------------------------------------------------------------------------
// window_gap_timer
// Loadable 8-bit down-counter that times the idle gap between lines.
//   clk      in  : clock
//   rst      in  : synchronous active-high reset, clears the count
//   clr      in  : synchronous clear (abort), same effect as rst
//   load     in  : load load_val into the count
//   load_val in  : reload value (1..255)
//   dec      in  : decrement the count by one (stops at zero)
//   expire   out : count is 1, i.e. this is the last gap cycle
// -----------------------------------------------------------------------------
module window_gap_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       expire
);

   logic [7:0] count_r;

   // Count register: clear, load, then decrement while enabled.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_r <= 8'd0;
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != 8'd0)) begin
         count_r <= count_r - 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // Expire on the cycle the count sits at 1 so the caller leaves GAP
   // exactly load_val cycles after the load.
   assign expire = (count_r == 8'd1);

endmodule

// File: rtl/window_adr_seq.sv
// -----------------------------------------------------------------------------
// window_adr_seq
// Sweeps one window base address per accepted beat across each line, inserts
// a GAP_CYC idle gap between lines, counts lines up to the programmed frame
// height and pulses line/frame completion.
//   clk        in  : clock
//   rst        in  : synchronous active-high reset
//   start      in  : begin a frame (ignored while busy)
//   abort      in  : return to IDLE next cycle, clears all outputs
//   line_len   in  : last column index, sampled at accepted start
//   num_lines  in  : last line index, sampled at accepted start
//   out_ready  in  : downstream accepts the current beat
//   reference  out : window base address
//   max        out : latched line_len (fan-out saturation limit)
//   center_col out : reference + HALF, mod 2^AW
//   out_valid  out : reference is valid
//   line_idx   out : current line index
//   line_done  out : one-cycle pulse after the last beat of a line
//   frame_done out : one-cycle pulse after the last beat of the frame
//   busy       out : state is not IDLE
// -----------------------------------------------------------------------------
import window_seq_pkg::*;

module window_adr_seq #(
   parameter int GAP_CYC = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] line_len,
   input  logic [AW-1:0] num_lines,
   input  logic          out_ready,
   output logic [AW-1:0] reference,
   output logic [AW-1:0] max,
   output logic [AW-1:0] center_col,
   output logic          out_valid,
   output logic [AW-1:0] line_idx,
   output logic          line_done,
   output logic          frame_done,
   output logic          busy
);

   seq_state_t    state_r;
   logic [AW-1:0] lines_q_r;

   logic          accept_s;
   logic          last_beat_s;
   logic          gap_load_s;
   logic          gap_dec_s;
   logic          gap_expire_s;
   logic [7:0]    gap_len_s;

   assign gap_len_s = 8'(GAP_CYC);

   // Beat handshake and gap-timer controls derived from the current state.
   always_comb begin
      accept_s    = out_valid & out_ready;
      last_beat_s = accept_s && (reference == max);
      gap_load_s  = 1'b0;
      gap_dec_s   = 1'b0;
      if ((state_r == S_RUN) && last_beat_s && (line_idx != lines_q_r)) begin
         gap_load_s = 1'b1;
      end else begin
         gap_load_s = 1'b0;
      end
      if (state_r == S_GAP) begin
         gap_dec_s = 1'b1;
      end else begin
         gap_dec_s = 1'b0;
      end
   end

   window_gap_timer u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (abort),
      .load     (gap_load_s),
      .load_val (gap_len_s),
      .dec      (gap_dec_s),
      .expire   (gap_expire_s)
   );

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_r    <= S_IDLE;
         lines_q_r  <= '0;
         reference  <= '0;
         max        <= '0;
         center_col <= '0;
         out_valid  <= 1'b0;
         line_idx   <= '0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Completion flags are single-cycle pulses.
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  max        <= line_len;
                  lines_q_r  <= num_lines;
                  reference  <= '0;
                  center_col <= calc_center('0);
                  line_idx   <= '0;
                  out_valid  <= 1'b1;
                  busy       <= 1'b1;
                  state_r    <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept_s) begin
                  if (reference != max) begin
                     reference  <= reference + 10'd1;
                     center_col <= calc_center(reference + 10'd1);
                  end else begin
                     line_done <= 1'b1;
                     out_valid <= 1'b0;
                     if (line_idx == lines_q_r) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= S_IDLE;
                     end else begin
                        // Timer was loaded by gap_load_s this same edge.
                        state_r <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_expire_s) begin
                  reference  <= '0;
                  center_col <= calc_center('0);
                  line_idx   <= line_idx + 10'd1;
                  out_valid  <= 1'b1;
                  state_r    <= S_RUN;
               end
            end
            default: begin
               state_r   <= S_IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_window_adr_seq.sv
// -----------------------------------------------------------------------------
// tb_window_adr_seq
// Directed self-checking bench for window_adr_seq (GAP_CYC = 4).
// -----------------------------------------------------------------------------
module tb_window_adr_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [9:0] line_len;
   logic [9:0] num_lines;
   logic       out_ready;
   logic [9:0] reference;
   logic [9:0] max_v;
   logic [9:0] center_col;
   logic       out_valid;
   logic [9:0] line_idx;
   logic       line_done;
   logic       frame_done;
   logic       busy;

   int total = 0;
   int bad   = 0;

   window_adr_seq #(.GAP_CYC(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .line_len   (line_len),
      .num_lines  (num_lines),
      .out_ready  (out_ready),
      .reference  (reference),
      .max        (max_v),
      .center_col (center_col),
      .out_valid  (out_valid),
      .line_idx   (line_idx),
      .line_done  (line_done),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 ns after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total++;
      if ({reference, max_v, center_col, line_idx} !== 40'd0) begin
         bad++;
         $display("FAIL reset_regs: got ref=%0d max=%0d ctr=%0d li=%0d want all 0", reference, max_v, center_col, line_idx);
      end
      total++;
      if ({out_valid, line_done, frame_done, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0000", {out_valid, line_done, frame_done, busy});
      end
   endtask

   // line_len=9, num_lines=0: ten beats then line_done+frame_done together.
   task automatic test_single_line;
      logic [9:0] exp_ref;
      line_len  = 10'd9;
      num_lines = 10'd0;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         exp_ref = 10'(i);
         total++;
         if (out_valid !== 1'b1 || reference !== exp_ref || busy !== 1'b1 || line_done !== 1'b0) begin
            bad++;
            $display("FAIL single_beat%0d: got v=%b ref=%0d busy=%b ld=%b want v=1 ref=%0d busy=1 ld=0", i, out_valid, reference, busy, line_done, exp_ref);
         end
         total++;
         if (center_col !== exp_ref + 10'd5) begin
            bad++;
            $display("FAIL single_center%0d: got %0d want %0d", i, center_col, exp_ref + 10'd5);
         end
         tick();
      end
      total++;
      if (line_done !== 1'b1 || frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_done: got ld=%b fd=%b busy=%b v=%b want 1 1 0 0", line_done, frame_done, busy, out_valid);
      end
      total++;
      if (max_v !== 10'd9) begin
         bad++;
         $display("FAIL single_max: got %0d want 9", max_v);
      end
      tick();
      total++;
      if (line_done !== 1'b0 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL single_pulse_width: got ld=%b fd=%b want 0 0", line_done, frame_done);
      end
   endtask

   // line_len=3, num_lines=2: 4 beats / 4 gap cycles per line, done at t+21.
   // Inputs are changed right after start to confirm they are latched.
   task automatic test_multi_line;
      int         p;
      int         ln;
      int         off;
      int         fd_cnt;
      logic       exp_v;
      logic       exp_ld;
      logic       exp_fd;
      logic       exp_busy;
      logic [9:0] exp_ref;
      logic [9:0] exp_li;
      line_len  = 10'd3;
      num_lines = 10'd2;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      line_len  = 10'd7;
      num_lines = 10'd0;
      fd_cnt    = 0;
      for (int k = 1; k <= 25; k++) begin
         p        = k - 1;
         ln       = (p / 8 > 2) ? 2 : p / 8;
         off      = p % 8;
         exp_v    = (k <= 20) && (off < 4);
         exp_ref  = 10'(off);
         exp_li   = 10'(ln);
         exp_ld   = (k == 5) || (k == 13) || (k == 21);
         exp_fd   = (k == 21);
         exp_busy = (k <= 20);
         total++;
         if (out_valid !== exp_v || line_idx !== exp_li || busy !== exp_busy) begin
            bad++;
            $display("FAIL multi_t%0d: got v=%b li=%0d busy=%b want v=%b li=%0d busy=%b", k, out_valid, line_idx, busy, exp_v, exp_li, exp_busy);
         end
         total++;
         if (line_done !== exp_ld || frame_done !== exp_fd) begin
            bad++;
            $display("FAIL multi_pulse_t%0d: got ld=%b fd=%b want ld=%b fd=%b", k, line_done, frame_done, exp_ld, exp_fd);
         end
         if (exp_v) begin
            total++;
            if (reference !== exp_ref) begin
               bad++;
               $display("FAIL multi_ref_t%0d: got %0d want %0d", k, reference, exp_ref);
            end
         end
         if (frame_done === 1'b1) fd_cnt++;
         tick();
      end
      total++;
      if (fd_cnt != 1) begin
         bad++;
         $display("FAIL multi_fd_count: got %0d want 1", fd_cnt);
      end
      total++;
      if (max_v !== 10'd3) begin
         bad++;
         $display("FAIL multi_max: got %0d want 3", max_v);
      end
   endtask

   // Stall three cycles at reference 5; sweep resumes at 6 and completes.
   task automatic test_backpressure;
      logic seen_fd;
      line_len  = 10'd9;
      num_lines = 10'd0;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (reference !== 10'd5) begin
         bad++;
         $display("FAIL bp_reach5: got %0d want 5", reference);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (reference !== 10'd5 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold%0d: got ref=%0d v=%b want ref=5 v=1", i, reference, out_valid);
         end
      end
      out_ready = 1'b1;
      tick();
      total++;
      if (reference !== 10'd6 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_resume: got ref=%0d v=%b want ref=6 v=1", reference, out_valid);
      end
      // Beats 6,7,8,9 remain; frame_done must follow within the budget.
      seen_fd = 1'b0;
      for (int i = 0; i < 10 && !seen_fd; i++) begin
         tick();
         if (frame_done === 1'b1) seen_fd = 1'b1;
      end
      total++;
      if (seen_fd !== 1'b1) begin
         bad++;
         $display("FAIL bp_frame_done: got no pulse within 10 cycles want pulse");
      end
   endtask

   // line_len=0, num_lines=1: beats in t+1 and t+6, frame_done in t+7.
   task automatic test_zero_len;
      logic       exp_v;
      logic       exp_ld;
      logic       exp_fd;
      logic [9:0] exp_li;
      line_len  = 10'd0;
      num_lines = 10'd1;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         exp_v  = (k == 1) || (k == 6);
         exp_ld = (k == 2) || (k == 7);
         exp_fd = (k == 7);
         exp_li = (k >= 6) ? 10'd1 : 10'd0;
         total++;
         if (out_valid !== exp_v || line_done !== exp_ld || frame_done !== exp_fd || line_idx !== exp_li) begin
            bad++;
            $display("FAIL zero_t%0d: got v=%b ld=%b fd=%b li=%0d want v=%b ld=%b fd=%b li=%0d", k, out_valid, line_done, frame_done, line_idx, exp_v, exp_ld, exp_fd, exp_li);
         end
         if (exp_v) begin
            total++;
            if (reference !== 10'd0) begin
               bad++;
               $display("FAIL zero_ref_t%0d: got %0d want 0", k, reference);
            end
         end
         tick();
      end
   endtask

   // Abort (with a simultaneous start) mid-GAP, then a clean relaunch.
   task automatic test_abort_gap;
      line_len  = 10'd1;
      num_lines = 10'd3;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_in_gap: got v=%b busy=%b want v=0 busy=1", out_valid, busy);
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if ({reference, max_v, center_col, line_idx} !== 40'd0 || {out_valid, line_done, frame_done, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL abort_clear: got ref=%0d max=%0d ctr=%0d li=%0d flags=%b want all 0", reference, max_v, center_col, line_idx, {out_valid, line_done, frame_done, busy});
      end
      line_len  = 10'd2;
      num_lines = 10'd0;
      tick();
      start = 1'b0;
      total++;
      if (out_valid !== 1'b1 || reference !== 10'd0 || line_idx !== 10'd0 || max_v !== 10'd2 || busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_relaunch: got v=%b ref=%0d li=%0d max=%0d busy=%b want 1 0 0 2 1", out_valid, reference, line_idx, max_v, busy);
      end
      tick();
      tick();
      tick();
      total++;
      if (frame_done !== 1'b1 || line_done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_relaunch_done: got fd=%b ld=%b busy=%b want 1 1 0", frame_done, line_done, busy);
      end
   endtask

   // start held high while busy, including the final-beat cycle, is ignored.
   task automatic test_start_busy;
      line_len  = 10'd4;
      num_lines = 10'd0;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      line_len = 10'd1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (reference !== 10'(i) || max_v !== 10'd4) begin
            bad++;
            $display("FAIL busy_start_ref%0d: got ref=%0d max=%0d want ref=%0d max=4", i, reference, max_v, i);
         end
      end
      // start is still high during this final-beat cycle.
      tick();
      start = 1'b0;
      total++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_done: got fd=%b busy=%b want 1 0", frame_done, busy);
      end
      tick();
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL busy_start_ignored: got busy=%b v=%b want 0 0", busy, out_valid);
      end
   endtask

   // rst during RUN returns every output to zero one cycle later.
   task automatic test_rst_run;
      line_len  = 10'd5;
      num_lines = 10'd2;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      total++;
      if (reference !== 10'd2 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_run_pre: got ref=%0d busy=%b want 2 1", reference, busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({reference, max_v, center_col, line_idx} !== 40'd0 || {out_valid, line_done, frame_done, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL rst_run_clear: got ref=%0d max=%0d ctr=%0d li=%0d flags=%b want all 0", reference, max_v, center_col, line_idx, {out_valid, line_done, frame_done, busy});
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      line_len  = 10'd0;
      num_lines = 10'd0;
      out_ready = 1'b0;
      test_reset();
      test_single_line();
      tick();
      test_multi_line();
      tick();
      test_backpressure();
      tick();
      test_zero_len();
      tick();
      test_abort_gap();
      tick();
      test_start_busy();
      tick();
      test_rst_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
